pwm_capture: RTL and testbench

- Measures a PWM waveform, such as the PWM generator's `pwm_out` looped back or an external PWM line.
- Reports period and high time in `clk` cycles per complete cycle of the waveform.
- Results are delivered over a valid/ready output port, with a stuck-line timeout and a dropped-result counter.
- Used for closed-loop checking of the PWM generator and for decoding external PWM inputs.

---
 rtl/pwm_capture_if.sv | 25 ++
 rtl/pwm_capture.sv | 144 ++++++++++++++
 tb/tb_pwm_capture.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// Result port of pwm_capture: measured period/high time with valid/ready handshake.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 32
);
    logic [CNT_W-1:0] meas_period;
    logic [CNT_W-1:0] meas_high;
    logic             meas_valid;
    logic             meas_ready;

    // Producer side (the capture block)
    modport master (
        output meas_period,
        output meas_high,
        output meas_valid,
        input  meas_ready
    );

    // Consumer side
    modport slave (
        input  meas_period,
        input  meas_high,
        input  meas_valid,
        output meas_ready
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles, one result
// per waveform cycle, with a stuck-line timeout and a saturating dropped-result count.
module pwm_capture #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    input  logic              enable,
    input  logic [CNT_W-1:0]  timeout_in,
    pwm_capture_if.master     meas,
    output logic [DROP_W-1:0] dropped_cnt,
    output logic              line_stuck,
    output logic              stuck_level
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    state_e            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  meas_period_q, meas_period_d;
    logic [CNT_W-1:0]  meas_high_q, meas_high_d;
    logic              meas_valid_q, meas_valid_d;
    logic [DROP_W-1:0] dropped_cnt_q, dropped_cnt_d;
    logic              line_stuck_q, line_stuck_d;
    logic              stuck_level_q, stuck_level_d;

    logic rise;
    logic publish;

    // Next-state: synchronizer, measurement FSM, timeout and output-port bookkeeping
    always_comb begin
        s1_d          = pwm_in;
        s2_d          = s1_q;
        s3_d          = s2_q;
        state_d       = state_q;
        period_cnt_d  = period_cnt_q;
        high_cnt_d    = high_cnt_q;
        meas_period_d = meas_period_q;
        meas_high_d   = meas_high_q;
        meas_valid_d  = meas_valid_q;
        dropped_cnt_d = dropped_cnt_q;
        line_stuck_d  = line_stuck_q;
        stuck_level_d = stuck_level_q;
        publish       = 1'b0;

        // Edge delay matches the level delay, so measured widths are exact
        rise = s2_q & ~s3_q;

        if (!enable) begin
            state_d      = StIdle;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            line_stuck_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d      = StMeasure;
                        period_cnt_d = CNT_W'(1);
                        high_cnt_d   = CNT_W'(1);
                        line_stuck_d = 1'b0;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        publish      = 1'b1;
                        period_cnt_d = CNT_W'(1);
                        high_cnt_d   = CNT_W'(1);
                    end else if ((timeout_in != '0) && (period_cnt_q == timeout_in)) begin
                        state_d       = StIdle;
                        period_cnt_d  = '0;
                        high_cnt_d    = '0;
                        line_stuck_d  = 1'b1;
                        stuck_level_d = s2_q;
                    end else begin
                        if (period_cnt_q != '1) begin
                            period_cnt_d = period_cnt_q + 1'b1;
                        end
                        if (s2_q && (high_cnt_q != '1)) begin
                            high_cnt_d = high_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Output register: a held, unaccepted result wins over a new one
        if (publish) begin
            if (!meas_valid_q || meas.meas_ready) begin
                meas_period_d = period_cnt_q;
                meas_high_d   = high_cnt_q;
                meas_valid_d  = 1'b1;
            end else if (dropped_cnt_q != '1) begin
                dropped_cnt_d = dropped_cnt_q + 1'b1;
            end
        end else if (meas_valid_q && meas.meas_ready) begin
            meas_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            period_cnt_q  <= '0;
            high_cnt_q    <= '0;
            meas_period_q <= '0;
            meas_high_q   <= '0;
            meas_valid_q  <= 1'b0;
            dropped_cnt_q <= '0;
            line_stuck_q  <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            period_cnt_q  <= period_cnt_d;
            high_cnt_q    <= high_cnt_d;
            meas_period_q <= meas_period_d;
            meas_high_q   <= meas_high_d;
            meas_valid_q  <= meas_valid_d;
            dropped_cnt_q <= dropped_cnt_d;
            line_stuck_q  <= line_stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign meas.meas_period = meas_period_q;
    assign meas.meas_high   = meas_high_q;
    assign meas.meas_valid  = meas_valid_q;
    assign dropped_cnt      = dropped_cnt_q;
    assign line_stuck       = line_stuck_q;
    assign stuck_level      = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM waveforms, expected results queued by the
// stimulus and checked by an independent monitor on each handshake transfer.
module tb_pwm_capture;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              pwm_in;
    logic              enable;
    logic [CNT_W-1:0]  timeout_in;
    logic [DROP_W-1:0] dropped_cnt;
    logic              line_stuck;
    logic              stuck_level;

    int checks = 0;
    int errors = 0;

    // Expected results as {period, high}
    logic [63:0] exp_q[$];

    pwm_capture_if #(.CNT_W(CNT_W)) mif ();

    pwm_capture #(
        .CNT_W (CNT_W),
        .DROP_W(DROP_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .enable     (enable),
        .timeout_in (timeout_in),
        .meas       (mif.master),
        .dropped_cnt(dropped_cnt),
        .line_stuck (line_stuck),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pwm_cycles(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            repeat (h) step();
            pwm_in = 1'b0;
            repeat (l) step();
        end
    endtask

    task automatic push_exp(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({p[31:0], h[31:0]});
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            step();
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: every transfer must match the next expected result
    always @(negedge clk) begin
        if (!rst && mif.meas_valid && mif.meas_ready) begin
            logic [63:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %0d/%0d expected none",
                         mif.meas_period, mif.meas_high);
            end else begin
                e = exp_q.pop_front();
                if ({mif.meas_period, mif.meas_high} !== e) begin
                    errors++;
                    $display("FAIL result: got %0d/%0d expected %0d/%0d",
                             mif.meas_period, mif.meas_high, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst            = 1'b1;
        pwm_in         = 1'b0;
        enable         = 1'b1;
        timeout_in     = '0;
        mif.meas_ready = 1'b1;
        apply_reset();

        // Reset state
        check("rst_valid", mif.meas_valid, 0);
        check("rst_period", mif.meas_period, 0);
        check("rst_high", mif.meas_high, 0);
        check("rst_dropped", dropped_cnt, 0);
        check("rst_stuck", line_stuck, 0);
        check("rst_stuck_level", stuck_level, 0);

        // 1: 3 high / 5 low, always ready
        push_exp(8, 3, 4);
        pwm_cycles(3, 5, 1);
        check("s1_no_first_result", mif.meas_valid, 0);
        pwm_cycles(3, 5, 3);
        pwm_in = 1'b1;
        step();
        pwm_in = 1'b0;
        drain("s1_drain");
        check("s1_dropped", dropped_cnt, 0);

        // 2: 1 high / 1 low
        apply_reset();
        push_exp(2, 1, 6);
        pwm_cycles(1, 1, 6);
        pwm_in = 1'b1;
        step();
        pwm_in = 1'b0;
        drain("s2_drain");
        check("s2_dropped", dropped_cnt, 0);

        // 3: backpressure across 4 results, then a single-cycle ready pulse
        apply_reset();
        mif.meas_ready = 1'b0;
        push_exp(8, 3, 1);
        pwm_cycles(3, 5, 4);
        pwm_in = 1'b1;
        step();
        pwm_in = 1'b0;
        repeat (5) step();
        check("s3_valid_held", mif.meas_valid, 1);
        check("s3_period_held", mif.meas_period, 8);
        check("s3_high_held", mif.meas_high, 3);
        check("s3_dropped", dropped_cnt, 3);
        mif.meas_ready = 1'b1;
        step();
        mif.meas_ready = 1'b0;
        check("s3_valid_after_pulse", mif.meas_valid, 0);
        check("s3_pulse_consumed", exp_q.size(), 0);

        // 4a: timeout with line held high
        apply_reset();
        mif.meas_ready = 1'b1;
        timeout_in     = 100;
        pwm_in         = 1'b1;
        repeat (102) step();
        check("s4a_not_yet_stuck", line_stuck, 0);
        step();
        check("s4a_stuck", line_stuck, 1);
        check("s4a_stuck_level", stuck_level, 1);
        check("s4a_valid", mif.meas_valid, 0);
        pwm_in = 1'b0;
        repeat (3) step();
        check("s4a_still_stuck", line_stuck, 1);
        pwm_in = 1'b1;
        repeat (4) step();
        check("s4a_cleared", line_stuck, 0);

        // 4b: timeout with line held low
        apply_reset();
        pwm_in = 1'b1;
        repeat (2) step();
        pwm_in = 1'b0;
        repeat (100) step();
        check("s4b_not_yet_stuck", line_stuck, 0);
        step();
        check("s4b_stuck", line_stuck, 1);
        check("s4b_stuck_level", stuck_level, 0);
        check("s4b_valid", mif.meas_valid, 0);
        timeout_in = '0;

        // 5: reset mid-period with a pending result
        apply_reset();
        mif.meas_ready = 1'b0;
        pwm_cycles(3, 5, 2);
        pwm_in = 1'b1;
        repeat (2) step();
        check("s5_pending", mif.meas_valid, 1);
        rst = 1'b1;
        step();
        check("s5_rst_valid", mif.meas_valid, 0);
        check("s5_rst_period", mif.meas_period, 0);
        check("s5_rst_high", mif.meas_high, 0);
        check("s5_rst_dropped", dropped_cnt, 0);
        check("s5_rst_stuck", line_stuck, 0);
        rst            = 1'b0;
        pwm_in         = 1'b0;
        mif.meas_ready = 1'b1;
        repeat (3) step();
        push_exp(8, 3, 1);
        pwm_cycles(3, 5, 1);
        check("s5_one_rise_no_result", mif.meas_valid, 0);
        pwm_cycles(3, 5, 1);
        drain("s5_drain");

        // 6: enable dropped mid-measurement with a pending result
        apply_reset();
        mif.meas_ready = 1'b0;
        push_exp(8, 3, 1);
        pwm_cycles(3, 5, 2);
        enable = 1'b0;
        pwm_in = 1'b1;
        repeat (3) step();
        pwm_in = 1'b0;
        repeat (7) step();
        enable = 1'b1;
        check("s6_retained_valid", mif.meas_valid, 1);
        check("s6_retained_period", mif.meas_period, 8);
        check("s6_retained_high", mif.meas_high, 3);
        check("s6_dropped", dropped_cnt, 0);
        mif.meas_ready = 1'b1;
        repeat (3) step();
        check("s6_retained_transferred", exp_q.size(), 0);
        push_exp(8, 3, 3);
        pwm_cycles(3, 5, 3);
        pwm_in = 1'b1;
        step();
        pwm_in = 1'b0;
        drain("s6_drain");
        check("s6_dropped_end", dropped_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
